// File: rtl/telemetry_frame_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_frame_encoder_if
// Brief    : Control, telemetry and character-read bundle for the encoder.
// Revision : 1.0
// ============================================================================
interface telemetry_frame_encoder_if #(
   parameter int NUM_SIGNALS = 7,
   parameter int VALUE_WIDTH = 9,
   parameter int BASE        = 10
);
   function automatic int calc_cols(input int vw, input int b);
      longint p;
      int     n;
      p = longint'(b);
      n = 1;
      for (int i = 0; i < 32; i++) begin
         if (p < (longint'(1) << vw)) begin
            p = p * longint'(b);
            n = n + 1;
         end
      end
      return n;
   endfunction

   localparam int NUM_COLS = calc_cols(VALUE_WIDTH, BASE);
   localparam int ROW_W    = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
   localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

   logic                                    frame_start;
   logic                                    freeze;
   logic                                    peak_clear;
   logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] telemetry_values;
   logic [ROW_W-1:0]                        rd_row;
   logic [COL_W-1:0]                        rd_col;
   logic [7:0]                              rd_char;
   logic                                    busy;
   logic                                    frame_done;
   logic                                    overrun;

   modport master (
      output frame_start, freeze, peak_clear, telemetry_values, rd_row, rd_col,
      input  rd_char, busy, frame_done, overrun
   );

   modport slave (
      input  frame_start, freeze, peak_clear, telemetry_values, rd_row, rd_col,
      output rd_char, busy, frame_done, overrun
   );
endinterface
`default_nettype wire

// File: rtl/telemetry_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_frame_encoder
// Brief    : Snapshots telemetry values and renders them as double-buffered
//            ASCII digits, one digit per clock.
// Revision : 1.0
// ============================================================================
module telemetry_frame_encoder #(
   parameter int NUM_SIGNALS = 7,
   parameter int VALUE_WIDTH = 9,
   parameter int BASE        = 10,
   parameter int ZERO_BLANK  = 0,
   parameter int PEAK_HOLD   = 0
) (
   input  wire logic                clk,
   input  wire logic                reset,
   telemetry_frame_encoder_if.slave bus
);
   function automatic int calc_cols(input int vw, input int b);
      longint p;
      int     n;
      p = longint'(b);
      n = 1;
      for (int i = 0; i < 32; i++) begin
         if (p < (longint'(1) << vw)) begin
            p = p * longint'(b);
            n = n + 1;
         end
      end
      return n;
   endfunction

   localparam int NUM_COLS = calc_cols(VALUE_WIDTH, BASE);
   localparam int ROW_W    = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
   localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int EW       = VALUE_WIDTH + 5;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_CONVERT = 2'd2;
   localparam logic [1:0] S_COMMIT  = 2'd3;

   logic [1:0]             r_state;
   logic                   r_front_sel;
   logic [ROW_W-1:0]       r_row;
   logic [COL_W-1:0]       r_dig;
   logic [VALUE_WIDTH-1:0] r_tmp;
   logic [7:0]             r_rd_char;
   logic                   r_frame_done;
   logic                   r_overrun;
   logic [VALUE_WIDTH-1:0] r_shadow [NUM_SIGNALS];
   logic [VALUE_WIDTH-1:0] r_peak   [NUM_SIGNALS];
   logic [7:0]             r_buf0   [NUM_SIGNALS][NUM_COLS];
   logic [7:0]             r_buf1   [NUM_SIGNALS][NUM_COLS];

   logic [VALUE_WIDTH-1:0] w_max [NUM_SIGNALS];
   logic [VALUE_WIDTH-1:0] w_cur;
   logic [EW-1:0]          w_ext;
   logic [VALUE_WIDTH-1:0] w_next_tmp;
   logic [3:0]             w_digit;
   logic [7:0]             w_char;
   logic [COL_W-1:0]       w_col;

   // A clear arriving with the load wins, so max(0, value) = value.
   always_comb begin
      for (int s = 0; s < NUM_SIGNALS; s++) begin
         if (bus.peak_clear || (bus.telemetry_values[s] > r_peak[s]))
            w_max[s] = bus.telemetry_values[s];
         else
            w_max[s] = r_peak[s];
      end
   end

   assign w_cur      = (r_dig == '0) ? r_shadow[r_row] : r_tmp;
   assign w_ext      = EW'(w_cur);
   assign w_next_tmp = VALUE_WIDTH'(w_ext / EW'(BASE));
   assign w_digit    = 4'(w_ext % EW'(BASE));
   assign w_col      = COL_W'(NUM_COLS - 1) - r_dig;

   always_comb begin
      if ((ZERO_BLANK != 0) && (r_dig != '0) && (w_cur == '0))
         w_char = 8'h20;
      else if (w_digit < 4'd10)
         w_char = 8'h30 + {4'h0, w_digit};
      else
         w_char = 8'h37 + {4'h0, w_digit};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_front_sel  <= 1'b0;
         r_row        <= '0;
         r_dig        <= '0;
         r_tmp        <= '0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (bus.frame_start && (r_state != S_IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.frame_start && !bus.freeze)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_row   <= '0;
               r_dig   <= '0;
               r_state <= S_CONVERT;
            end
            S_CONVERT: begin
               r_tmp <= w_next_tmp;
               if (r_dig == COL_W'(NUM_COLS - 1)) begin
                  r_dig <= '0;
                  if (r_row == ROW_W'(NUM_SIGNALS - 1))
                     r_state <= S_COMMIT;
                  else
                     r_row <= r_row + ROW_W'(1);
               end else begin
                  r_dig <= r_dig + COL_W'(1);
               end
            end
            default: begin
               r_front_sel  <= ~r_front_sel;
               r_frame_done <= 1'b1;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SIGNALS; s++) begin
            r_shadow[s] <= '0;
            r_peak[s]   <= '0;
         end
      end else if (r_state == S_LOAD) begin
         for (int s = 0; s < NUM_SIGNALS; s++) begin
            r_peak[s]   <= w_max[s];
            r_shadow[s] <= (PEAK_HOLD != 0) ? w_max[s] : bus.telemetry_values[s];
         end
      end else if (bus.peak_clear) begin
         for (int s = 0; s < NUM_SIGNALS; s++)
            r_peak[s] <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SIGNALS; s++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
               r_buf0[s][c] <= 8'h2D;
               r_buf1[s][c] <= 8'h2D;
            end
         end
      end else if (r_state == S_CONVERT) begin
         if (r_front_sel)
            r_buf0[r_row][w_col] <= w_char;
         else
            r_buf1[r_row][w_col] <= w_char;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_rd_char <= 8'h20;
      else if ((int'(bus.rd_row) >= NUM_SIGNALS) || (int'(bus.rd_col) >= NUM_COLS))
         r_rd_char <= 8'h20;
      else if (r_front_sel)
         r_rd_char <= r_buf1[bus.rd_row][bus.rd_col];
      else
         r_rd_char <= r_buf0[bus.rd_row][bus.rd_col];
   end

   assign bus.rd_char    = r_rd_char;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.frame_done = r_frame_done;
   assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_telemetry_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_telemetry_frame_encoder
// Brief    : Directed scoreboard bench over five encoder configurations.
// Revision : 1.0
// ============================================================================
module tb_telemetry_frame_encoder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   telemetry_frame_encoder_if #(.NUM_SIGNALS(7), .VALUE_WIDTH(9), .BASE(10)) if0();
   telemetry_frame_encoder_if #(.NUM_SIGNALS(7), .VALUE_WIDTH(9), .BASE(10)) if1();
   telemetry_frame_encoder_if #(.NUM_SIGNALS(1), .VALUE_WIDTH(9), .BASE(16)) if2();
   telemetry_frame_encoder_if #(.NUM_SIGNALS(1), .VALUE_WIDTH(9), .BASE(2))  if3();
   telemetry_frame_encoder_if #(.NUM_SIGNALS(1), .VALUE_WIDTH(9), .BASE(10)) if4();

   telemetry_frame_encoder #(.NUM_SIGNALS(7), .VALUE_WIDTH(9), .BASE(10), .ZERO_BLANK(0), .PEAK_HOLD(0))
      u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   telemetry_frame_encoder #(.NUM_SIGNALS(7), .VALUE_WIDTH(9), .BASE(10), .ZERO_BLANK(1), .PEAK_HOLD(0))
      u1 (.clk(clk), .reset(reset), .bus(if1.slave));
   telemetry_frame_encoder #(.NUM_SIGNALS(1), .VALUE_WIDTH(9), .BASE(16), .ZERO_BLANK(0), .PEAK_HOLD(0))
      u2 (.clk(clk), .reset(reset), .bus(if2.slave));
   telemetry_frame_encoder #(.NUM_SIGNALS(1), .VALUE_WIDTH(9), .BASE(2), .ZERO_BLANK(0), .PEAK_HOLD(0))
      u3 (.clk(clk), .reset(reset), .bus(if3.slave));
   telemetry_frame_encoder #(.NUM_SIGNALS(1), .VALUE_WIDTH(9), .BASE(10), .ZERO_BLANK(0), .PEAK_HOLD(1))
      u4 (.clk(clk), .reset(reset), .bus(if4.slave));

   typedef struct {
      int         id;
      int         row;
      int         col;
      logic [7:0] ch;
   } rd_t;

   rd_t  exp_q[$];
   int   done_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic rd_issue = 1'b0;
   logic rd_pend  = 1'b0;
   int   rd_issue_id = 0;
   int   rd_pend_id  = 0;

   int    vals_a[7] = '{511, 7, 0, 100, 42, 255, 1};
   int    vals_z[7] = '{0, 0, 0, 0, 0, 0, 0};
   int    vals_b[7] = '{123, 456, 78, 9, 0, 300, 511};
   string rows_a[7]  = '{"511", "007", "000", "100", "042", "255", "001"};
   string rows_zb[7] = '{"511", "  7", "  0", "100", " 42", "255", "  1"};
   string rows_b[7]  = '{"123", "456", "078", "009", "000", "300", "511"};

   task automatic check(input string name, input int got, input int expv);
      n_total++;
      if (got == expv)
         n_pass++;
      else
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, got, got, expv, expv, cyc);
   endtask

   function automatic logic [7:0] get_char(input int id);
      case (id)
         0: return if0.rd_char;
         1: return if1.rd_char;
         2: return if2.rd_char;
         3: return if3.rd_char;
         default: return if4.rd_char;
      endcase
   endfunction

   function automatic logic get_done(input int id);
      case (id)
         0: return if0.frame_done;
         1: return if1.frame_done;
         2: return if2.frame_done;
         3: return if3.frame_done;
         default: return if4.frame_done;
      endcase
   endfunction

   // Read scoreboard: a read issued before edge P is answered after edge P.
   always @(posedge clk) begin
      rd_pend    <= rd_issue;
      rd_pend_id <= rd_issue_id;
   end

   always @(negedge clk) begin
      rd_t e;
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            check("rd_unexpected", int'(get_char(rd_pend_id)), -1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("rd_d%0d_r%0d_c%0d", e.id, e.row, e.col),
                  int'(get_char(rd_pend_id)), int'(e.ch));
         end
      end
   end

   always @(negedge clk) begin
      if (reset && if0.frame_done) begin
         if (done_q.size() == 0)
            check("d0_unexpected_done", cyc, -1);
         else
            check("d0_done_cycle", cyc, done_q.pop_front());
      end
   end

   task automatic set_start(input int id, input logic v);
      case (id)
         0: if0.frame_start = v;
         1: if1.frame_start = v;
         2: if2.frame_start = v;
         3: if3.frame_start = v;
         default: if4.frame_start = v;
      endcase
   endtask

   task automatic pulse_start(input int id);
      set_start(id, 1'b1);
      @(posedge clk); #1;
      set_start(id, 1'b0);
   endtask

   task automatic set_vals(input int id, input int v[7]);
      for (int s = 0; s < 7; s++) begin
         if (id == 0) if0.telemetry_values[s] = 9'(v[s]);
         else         if1.telemetry_values[s] = 9'(v[s]);
      end
   endtask

   task automatic issue_read(input int id, input int row, input int col, input logic [7:0] ch);
      case (id)
         0: begin if0.rd_row = 3'(row); if0.rd_col = 2'(col); end
         1: begin if1.rd_row = 3'(row); if1.rd_col = 2'(col); end
         2: begin if2.rd_row = 1'(row); if2.rd_col = 2'(col); end
         3: begin if3.rd_row = 1'(row); if3.rd_col = 4'(col); end
         default: begin if4.rd_row = 1'(row); if4.rd_col = 2'(col); end
      endcase
      rd_issue_id = id;
      rd_issue    = 1'b1;
      exp_q.push_back('{id, row, col, ch});
      @(posedge clk); #1;
      rd_issue = 1'b0;
   endtask

   task automatic read_str(input int id, input int row, input string s);
      for (int c = 0; c < s.len(); c++)
         issue_read(id, row, c, s[c]);
   endtask

   task automatic wait_done(input int id, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (get_done(id)) seen = 1'b1;
      end
      check(name, int'(seen), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      if0.frame_start = 0; if0.freeze = 0; if0.peak_clear = 0; if0.rd_row = 0; if0.rd_col = 0;
      if1.frame_start = 0; if1.freeze = 0; if1.peak_clear = 0; if1.rd_row = 0; if1.rd_col = 0;
      if2.frame_start = 0; if2.freeze = 0; if2.peak_clear = 0; if2.rd_row = 0; if2.rd_col = 0;
      if3.frame_start = 0; if3.freeze = 0; if3.peak_clear = 0; if3.rd_row = 0; if3.rd_col = 0;
      if4.frame_start = 0; if4.freeze = 0; if4.peak_clear = 0; if4.rd_row = 0; if4.rd_col = 0;
      set_vals(0, vals_z);
      set_vals(1, vals_z);
      if2.telemetry_values = '0;
      if3.telemetry_values = '0;
      if4.telemetry_values = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(if0.busy), 0);
      check("rst_overrun", int'(if0.overrun), 0);
      check("rst_frame_done", int'(if0.frame_done), 0);
      check("rst_rd_char", int'(if0.rd_char), 32);
      reset = 1'b1;
      @(posedge clk); #1;

      read_str(0, 0, "---");
      read_str(3, 0, "---------");

      // Main frame with a dropped second request and live values changing mid-conversion.
      set_vals(0, vals_a);
      done_q.push_back(cyc + 24);
      pulse_start(0);
      check("d0_busy_load", int'(if0.busy), 1);
      repeat (3) begin @(posedge clk); #1; end
      set_vals(0, vals_z);
      pulse_start(0);
      check("d0_overrun_set", int'(if0.overrun), 1);
      wait_done(0, "d0_done_seen");
      check("d0_busy_at_done", int'(if0.busy), 0);
      @(posedge clk); #1;
      check("d0_done_one_cycle", int'(if0.frame_done), 0);
      for (int r = 0; r < 7; r++) read_str(0, r, rows_a[r]);
      check("d0_overrun_sticky", int'(if0.overrun), 1);
      repeat (30) begin @(posedge clk); #1; end

      if0.freeze = 1'b1;
      pulse_start(0);
      check("d0_freeze_busy", int'(if0.busy), 0);
      repeat (2) begin @(posedge clk); #1; end
      check("d0_freeze_busy2", int'(if0.busy), 0);
      if0.freeze = 1'b0;
      read_str(0, 0, "511");
      issue_read(0, 7, 0, 8'h20);
      issue_read(0, 0, 3, 8'h20);

      set_vals(1, vals_a);
      pulse_start(1);
      wait_done(1, "d1_done_seen");
      for (int r = 0; r < 7; r++) read_str(1, r, rows_zb[r]);

      if2.telemetry_values[0] = 9'h1AB;
      pulse_start(2);
      wait_done(2, "d2_done_seen");
      read_str(2, 0, "1AB");

      if3.telemetry_values[0] = 9'd5;
      pulse_start(3);
      wait_done(3, "d3_done_seen");
      read_str(3, 0, "000000101");

      if4.telemetry_values[0] = 9'd300;
      pulse_start(4);
      wait_done(4, "d4_done_300");
      read_str(4, 0, "300");
      if4.telemetry_values[0] = 9'd120;
      pulse_start(4);
      wait_done(4, "d4_done_hold");
      read_str(4, 0, "300");
      if4.peak_clear = 1'b1;
      @(posedge clk); #1;
      if4.peak_clear = 1'b0;
      pulse_start(4);
      wait_done(4, "d4_done_clear");
      read_str(4, 0, "120");

      // Reset during conversion aborts the frame.
      set_vals(0, vals_b);
      pulse_start(0);
      repeat (9) begin @(posedge clk); #1; end
      check("abort_busy_before", int'(if0.busy), 1);
      reset = 1'b0;
      #1;
      check("abort_busy_async", int'(if0.busy), 0);
      check("abort_overrun_clr", int'(if0.overrun), 0);
      check("abort_rd_char", int'(if0.rd_char), 32);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy_after", int'(if0.busy), 0);
      read_str(0, 0, "---");
      read_str(0, 6, "---");
      repeat (40) begin @(posedge clk); #1; end

      set_vals(0, vals_b);
      done_q.push_back(cyc + 24);
      pulse_start(0);
      wait_done(0, "d0_post_reset_done");
      for (int r = 0; r < 7; r++) read_str(0, r, rows_b[r]);

      repeat (3) begin @(posedge clk); #1; end
      check("rd_queue_drained", exp_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/telemetry_frame_encoder.md
TELEMETRY_FRAME_ENCODER -- requirements
Module: telemetry_frame_encoder

Interface
REQ-001 SHALL have parameter NUM_SIGNALS, default 7: number of telemetry rows (1..32).
REQ-002 SHALL have parameter VALUE_WIDTH, default 9: bits per telemetry value (1..24).
REQ-003 SHALL have parameter BASE, default 10: display radix (2..16); digits 0-9 as "0"-"9", 10-15 as "A"-"F".
REQ-004 SHALL have parameter ZERO_BLANK, default 0: 1 = leading zeros shown as space (0x20); least-significant digit always shown.
REQ-005 SHALL have parameter PEAK_HOLD, default 0: 1 = each row displays its running maximum instead of its live value.
REQ-006 SHALL derive localparam NUM_COLS: smallest n >= 1 with BASE^n >= 2^VALUE_WIDTH (9-bit/base 10 -> 3; 9-bit/base 16 -> 3; 9-bit/base 2 -> 9).
REQ-007 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: frame_start  in  1  one-cycle snapshot request (from VGA frame boundary); freeze  in  1  suppress snapshots; peak_clear  in  1  one-cycle clear of peak registers.
REQ-009 SHALL have port telemetry_values  in  [VALUE_WIDTH-1:0] x NUM_SIGNALS  live values.
REQ-010 SHALL have ports rd_row  in  clog2(NUM_SIGNALS) bits, rd_col  in  clog2(NUM_COLS) bits  character read address; rd_char  out  8  ASCII at that address.
REQ-011 SHALL have ports busy  out  1; frame_done  out  1  one-cycle commit pulse; overrun  out  1  sticky dropped-request flag.

Function
REQ-012 SHALL hold two character buffers (front, back), each NUM_SIGNALS x NUM_COLS x 8 bits; reads use front only, conversion writes back only.
REQ-013 SHALL implement FSM IDLE -> LOAD -> CONVERT -> COMMIT -> IDLE.
REQ-014 IDLE: frame_start=1 and freeze=0 -> LOAD; frame_start with freeze=1 ignored, no flag.
REQ-015 LOAD (1 cycle): shadow[s] = telemetry_values[s] for all s; with PEAK_HOLD=1, shadow[s] = max(peak[s], value) and peak[s] updated to the same.
REQ-016 CONVERT: exactly one digit per cycle, row 0 first, each row LSD first; digit = tmp mod BASE written to back[s][NUM_COLS-1-k], tmp = tmp / BASE; NUM_SIGNALS*NUM_COLS cycles total.
REQ-017 ZERO_BLANK=1: digit k>0 written as space when the remaining value before that step is 0.
REQ-018 COMMIT (1 cycle): swap front/back; frame_done=1 for this cycle only; then IDLE.
REQ-019 Latency: frame_start sampled at edge N -> frame_done high in cycle N+2+NUM_SIGNALS*NUM_COLS (9-bit, base 10, 7 rows: N+23); new data visible on rd_char for reads issued after that edge.
REQ-020 busy SHALL be 1 in LOAD, CONVERT, COMMIT; 0 in IDLE.
REQ-021 frame_start while busy=1 SHALL be dropped (no queueing) and set overrun=1; overrun cleared only by reset.
REQ-022 peak_clear SHALL zero all peak registers; coincident with LOAD, clear applies first (shadow = live value).
REQ-023 rd_char SHALL be registered, 1-cycle latency; read sampled on the COMMIT edge returns pre-swap front data.
REQ-024 rd_row >= NUM_SIGNALS or rd_col >= NUM_COLS SHALL return 0x20.
REQ-025 Values change mid-conversion SHALL NOT affect the frame being converted (shadow only).

Reset
REQ-026 reset=0 SHALL asynchronously force: FSM IDLE; busy, frame_done, overrun = 0; rd_char = 0x20; peak and shadow = 0; all cells of both buffers = "-" (0x2D).
REQ-027 reset asserted mid-CONVERT SHALL abort conversion; front buffer reads "-" after release; no frame_done.
REQ-028 First frame_start after reset release SHALL be honoured normally.

Verification
REQ-029 Defaults, values {511,7,0,100,42,255,1}, frame_start -> frame_done at +23 cycles; rows read "511","007","000","100","042","255","001".
REQ-030 ZERO_BLANK=1, same values -> rows "511","  7","  0","100"," 42","255","  1".
REQ-031 BASE=16, value 0x1AB -> "1AB"; BASE=2, value 5 -> "000000101".
REQ-032 frame_start again at +5 cycles -> ignored, overrun=1 stays; frame_start with freeze=1 in IDLE -> busy stays 0, buffer unchanged.
REQ-033 PEAK_HOLD=1: row0 frames 300, 120 -> "300","300"; peak_clear then 120 -> "120".
REQ-034 Reset at cycle +10 of conversion -> busy=0, all reads "-", no frame_done; next frame_start completes normally.
